mem_stage_ctrl: RTL and testbench

//  Consumer end of the EX/MEM pipeline register: the MEM stage plus MEM/WB register.

---
 rtl/mem_stage_pkg.sv | 26 ++
 rtl/mem_wb_reg.sv | 82 ++++++++
 rtl/mem_stage_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_stage_pkg
//   Shared definitions for the MEM stage controller and its MEM/WB register:
//   the default datapath and register-address widths, and the encoding of the
//   two-state data-memory handshake FSM.
//
//   Contents
//     XLEN_DEF  default datapath / address width
//     RA_W_DEF  default register-address width
//     state_t   FSM state type, values S_IDLE and S_WAIT
// -----------------------------------------------------------------------------
package mem_stage_pkg;

    localparam int XLEN_DEF = 64;
    localparam int RA_W_DEF = 5;

    // The state is kept as plain localparam constants rather than an enum so
    // the encoding stays visible to older tools and netlist readers.
    typedef logic [0:0] state_t;

    // IDLE: no access outstanding across a clock edge.
    localparam state_t S_IDLE = 1'b0;
    // WAIT: a request was issued and not yet acknowledged; dmem_req is held.
    localparam state_t S_WAIT = 1'b1;

endpackage : mem_stage_pkg

// File: rtl/mem_wb_reg.sv
// -----------------------------------------------------------------------------
// mem_wb_reg
//   MEM/WB pipeline register. On every clock edge it either captures the
//   instruction leaving the MEM stage or inserts a bubble. A bubble clears
//   only the writeback control bits; the data fields keep their old values,
//   since nothing downstream consumes them without reg_write set.
//
//   Ports
//     clk            in   clock, rising edge
//     rst_n          in   asynchronous active-low reset, clears every field
//     bubble_i       in   1: write a bubble instead of capturing
//     load_rdata_i   in   1: a read completed this cycle, capture rdata_i
//     rd_i           in   destination register of the leaving instruction
//     alu_result_i   in   ALU result of the leaving instruction
//     rdata_i        in   data-memory read data
//     mem_to_reg_i   in   writeback source select
//     reg_write_i    in   register-file write enable
//     rd_o, alu_result_o, read_data_o, mem_to_reg_o, reg_write_o
//                    out  registered MEM/WB fields
// -----------------------------------------------------------------------------
module mem_wb_reg
    import mem_stage_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int RA_W = RA_W_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            bubble_i,
    input  logic            load_rdata_i,
    input  logic [RA_W-1:0] rd_i,
    input  logic [XLEN-1:0] alu_result_i,
    input  logic [XLEN-1:0] rdata_i,
    input  logic            mem_to_reg_i,
    input  logic            reg_write_i,
    output logic [RA_W-1:0] rd_o,
    output logic [XLEN-1:0] alu_result_o,
    output logic [XLEN-1:0] read_data_o,
    output logic            mem_to_reg_o,
    output logic            reg_write_o
);

    logic [RA_W-1:0] rd_q;
    logic [XLEN-1:0] alu_result_q;
    logic [XLEN-1:0] read_data_q;
    logic            mem_to_reg_q;
    logic            reg_write_q;

    // NOTE: every field is reset, data included, so a freshly reset pipeline
    // shows all-zero MEM/WB contents and can never issue a phantom write.
    // NOTE: sequential logic uses non-blocking assignments only, so all
    // flops sample pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q         <= '0;
            alu_result_q <= '0;
            read_data_q  <= '0;
            mem_to_reg_q <= 1'b0;
            reg_write_q  <= 1'b0;
        end else if (bubble_i) begin
            mem_to_reg_q <= 1'b0;
            reg_write_q  <= 1'b0;
        end else begin
            rd_q         <= rd_i;
            alu_result_q <= alu_result_i;
            mem_to_reg_q <= mem_to_reg_i;
            reg_write_q  <= reg_write_i;
            // Read data only moves when a load actually finished; otherwise
            // the previous value is held.
            if (load_rdata_i) begin
                read_data_q <= rdata_i;
            end
        end
    end

    assign rd_o         = rd_q;
    assign alu_result_o = alu_result_q;
    assign read_data_o  = read_data_q;
    assign mem_to_reg_o = mem_to_reg_q;
    assign reg_write_o  = reg_write_q;

endmodule : mem_wb_reg

// File: rtl/mem_stage_ctrl.sv
// -----------------------------------------------------------------------------
// mem_stage_ctrl
//   MEM stage of the pipeline plus the MEM/WB register. Consumes the EX/MEM
//   register outputs, runs the data-memory req/ack handshake, resolves
//   branches, stalls upstream while an access is outstanding and registers the
//   results for writeback.
//
//   Configuration macro
//     MEM_TIMEOUT_EN  when defined, an access that waits TIMEOUT_CYCLES cycles
//                     in WAIT without ack is aborted: the request is dropped,
//                     the stall released, a bubble written to MEM/WB and the
//                     sticky mem_err flag set. When undefined, WAIT lasts until
//                     ack and mem_err is tied low.
//
//   Ports
//     clk             in   clock, rising edge
//     reset           in   asynchronous active-low reset
//     adder_in        in   branch target from EX/MEM
//     zero_in         in   ALU zero flag
//     alu_result_in   in   ALU result / memory address
//     read_data2_in   in   store data
//     rd_in           in   destination register
//     mem_to_reg_in, reg_write_in, branch_in, mem_read_in, mem_write_in
//                     in   control bits from EX/MEM
//     pc_src          out  take branch (also flushes IF/ID, ID/EX, EX/MEM)
//     branch_target   out  = adder_in
//     stall           out  hold PC, IF/ID, ID/EX, EX/MEM this cycle
//     dmem_req        out  data-memory request
//     dmem_we         out  1 = write, 0 = read
//     dmem_addr       out  = alu_result_in
//     dmem_wdata      out  = read_data2_in
//     dmem_ack        in   request accepted/complete this cycle
//     dmem_rdata      in   read data, valid with dmem_ack
//     wb_read_data, wb_alu_result, wb_rd, wb_mem_to_reg, wb_reg_write
//                     out  MEM/WB register contents
//     mem_err         out  sticky access-timeout flag
// -----------------------------------------------------------------------------
module mem_stage_ctrl
    import mem_stage_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int RA_W = RA_W_DEF
`ifdef MEM_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 16
`endif
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] adder_in,
    input  logic            zero_in,
    input  logic [XLEN-1:0] alu_result_in,
    input  logic [XLEN-1:0] read_data2_in,
    input  logic [RA_W-1:0] rd_in,
    input  logic            mem_to_reg_in,
    input  logic            reg_write_in,
    input  logic            branch_in,
    input  logic            mem_read_in,
    input  logic            mem_write_in,
    output logic            pc_src,
    output logic [XLEN-1:0] branch_target,
    output logic            stall,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_ack,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic [XLEN-1:0] wb_read_data,
    output logic [XLEN-1:0] wb_alu_result,
    output logic [RA_W-1:0] wb_rd,
    output logic            wb_mem_to_reg,
    output logic            wb_reg_write,
    output logic            mem_err
);

    state_t state_q, state_d;
    logic   access;
    logic   abort;
    logic   read_done;

    assign access = mem_read_in | mem_write_in;

    // ------------------------------------------------------------------
    // Memory interface. Address and data are pure pass-through: the stall
    // holds EX/MEM, so they stay stable for the whole WAIT period.
    // ------------------------------------------------------------------
    assign dmem_addr  = alu_result_in;
    assign dmem_wdata = read_data2_in;
    // When both read and write are flagged, the write wins.
    assign dmem_we    = mem_write_in;

    // NOTE: every signal assigned in an always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        dmem_req = 1'b0;
        if (reset) begin
            dmem_req = (state_q == S_WAIT) ? !abort : access;
        end
    end

    // An ack while no request is pending is ignored because dmem_req gates it.
    assign stall     = dmem_req & ~dmem_ack;
    assign read_done = dmem_req & dmem_ack & mem_read_in & ~mem_write_in;

    // Branch resolution is independent of the memory handshake.
    assign pc_src        = reset & branch_in & zero_in;
    assign branch_target = adder_in;

    // ------------------------------------------------------------------
    // Handshake FSM. A zero-wait ack completes in IDLE without leaving it.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (state_q == S_IDLE) begin
            if (access && !dmem_ack) begin
                state_d = S_WAIT;
            end
        end else begin
            // The abort check comes first: a late ack in the abort cycle sees
            // dmem_req low and must not count as completion.
            if (abort || dmem_ack) begin
                state_d = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef MEM_TIMEOUT_EN
    // ------------------------------------------------------------------
    // Timeout. cnt_q counts completed WAIT cycles; once it reaches
    // TIMEOUT_CYCLES the following WAIT cycle is the abort cycle, in which
    // the request and stall are released and a bubble enters MEM/WB.
    // ------------------------------------------------------------------
    localparam int               CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_err_q, mem_err_d;

    assign abort = (state_q == S_WAIT) && (cnt_q == CNT_LIMIT);

    // Restart from zero on every entry into WAIT; count only while staying.
    always_comb begin
        cnt_d = '0;
        if ((state_q == S_WAIT) && (state_d == S_WAIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign mem_err_d = mem_err_q | abort;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q     <= '0;
            mem_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            mem_err_q <= mem_err_d;
        end
    end

    assign mem_err = mem_err_q;
`else
    assign abort   = 1'b0;
    assign mem_err = 1'b0;
`endif

    // ------------------------------------------------------------------
    // MEM/WB register. A stalled cycle leaves the instruction in MEM, and an
    // aborted access retires with no writeback, so both insert a bubble.
    // ------------------------------------------------------------------
    mem_wb_reg #(
        .XLEN (XLEN),
        .RA_W (RA_W)
    ) u_mem_wb_reg (
        .clk          (clk),
        .rst_n        (reset),
        .bubble_i     (stall | abort),
        .load_rdata_i (read_done),
        .rd_i         (rd_in),
        .alu_result_i (alu_result_in),
        .rdata_i      (dmem_rdata),
        .mem_to_reg_i (mem_to_reg_in),
        .reg_write_i  (reg_write_in),
        .rd_o         (wb_rd),
        .alu_result_o (wb_alu_result),
        .read_data_o  (wb_read_data),
        .mem_to_reg_o (wb_mem_to_reg),
        .reg_write_o  (wb_reg_write)
    );

endmodule : mem_stage_ctrl

// File: tb/tb_mem_stage_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_stage_ctrl
//   Self-checking bench for mem_stage_ctrl. Directed scenarios (zero-wait
//   load, multi-cycle store, branch, reset during WAIT, read+write conflict,
//   stray ack, and the access timeout when MEM_TIMEOUT_EN is defined) are
//   followed by randomized traffic. Every cycle is compared against a
//   behavioural model that tracks "access outstanding" and the MEM/WB
//   contents directly from the stage's rules.
// -----------------------------------------------------------------------------
module tb_mem_stage_ctrl;

    localparam int XLEN = 64;
    localparam int RA_W = 5;
`ifdef MEM_TIMEOUT_EN
    localparam int TO = 16;
`endif

    typedef struct {
        logic            rd;
        logic            wr;
        logic            br;
        logic            z;
        logic            ack;
        logic            m2r;
        logic            rw;
        logic [RA_W-1:0] dst;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
        logic [XLEN-1:0] tgt;
        logic [XLEN-1:0] rdata;
    } stim_t;

    logic            clk;
    logic            reset;
    logic [XLEN-1:0] adder_in;
    logic            zero_in;
    logic [XLEN-1:0] alu_result_in;
    logic [XLEN-1:0] read_data2_in;
    logic [RA_W-1:0] rd_in;
    logic            mem_to_reg_in;
    logic            reg_write_in;
    logic            branch_in;
    logic            mem_read_in;
    logic            mem_write_in;
    logic            pc_src;
    logic [XLEN-1:0] branch_target;
    logic            stall;
    logic            dmem_req;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [XLEN-1:0] dmem_wdata;
    logic            dmem_ack;
    logic [XLEN-1:0] dmem_rdata;
    logic [XLEN-1:0] wb_read_data;
    logic [XLEN-1:0] wb_alu_result;
    logic [RA_W-1:0] wb_rd;
    logic            wb_mem_to_reg;
    logic            wb_reg_write;
    logic            mem_err;

    mem_stage_ctrl #(
        .XLEN (XLEN),
        .RA_W (RA_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .adder_in      (adder_in),
        .zero_in       (zero_in),
        .alu_result_in (alu_result_in),
        .read_data2_in (read_data2_in),
        .rd_in         (rd_in),
        .mem_to_reg_in (mem_to_reg_in),
        .reg_write_in  (reg_write_in),
        .branch_in     (branch_in),
        .mem_read_in   (mem_read_in),
        .mem_write_in  (mem_write_in),
        .pc_src        (pc_src),
        .branch_target (branch_target),
        .stall         (stall),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_ack      (dmem_ack),
        .dmem_rdata    (dmem_rdata),
        .wb_read_data  (wb_read_data),
        .wb_alu_result (wb_alu_result),
        .wb_rd         (wb_rd),
        .wb_mem_to_reg (wb_mem_to_reg),
        .wb_reg_write  (wb_reg_write),
        .mem_err       (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [XLEN-1:0] got,
                         input logic [XLEN-1:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model state ----------------
    bit              m_busy;     // an access is outstanding across an edge
    int              m_waited;   // edges spent waiting after the first one
    bit              m_err;
    logic [RA_W-1:0] m_wb_rd;
    logic [XLEN-1:0] m_wb_alu;
    logic [XLEN-1:0] m_wb_rdata;
    logic            m_wb_m2r;
    logic            m_wb_rw;

    task automatic model_reset();
        m_busy     = 0;
        m_waited   = 0;
        m_err      = 0;
        m_wb_rd    = '0;
        m_wb_alu   = '0;
        m_wb_rdata = '0;
        m_wb_m2r   = 1'b0;
        m_wb_rw    = 1'b0;
    endtask

    task automatic check_wb();
        check("wb_rd",         {{(XLEN-RA_W){1'b0}}, wb_rd}, {{(XLEN-RA_W){1'b0}}, m_wb_rd});
        check("wb_alu_result", wb_alu_result, m_wb_alu);
        check("wb_read_data",  wb_read_data,  m_wb_rdata);
        check("wb_mem_to_reg", {63'd0, wb_mem_to_reg}, {63'd0, m_wb_m2r});
        check("wb_reg_write",  {63'd0, wb_reg_write},  {63'd0, m_wb_rw});
        check("mem_err",       {63'd0, mem_err},       {63'd0, m_err});
    endtask

    // One clock cycle: drive at negedge, check combinational outputs, let the
    // edge happen, advance the model, check MEM/WB.
    task automatic step(input stim_t s);
        bit access, abort, req, stl;
        @(negedge clk);
        mem_read_in   = s.rd;
        mem_write_in  = s.wr;
        branch_in     = s.br;
        zero_in       = s.z;
        dmem_ack      = s.ack;
        mem_to_reg_in = s.m2r;
        reg_write_in  = s.rw;
        rd_in         = s.dst;
        alu_result_in = s.addr;
        read_data2_in = s.wdata;
        adder_in      = s.tgt;
        dmem_rdata    = s.rdata;
        #1;
        access = s.rd | s.wr;
        abort  = 0;
`ifdef MEM_TIMEOUT_EN
        abort  = m_busy && (m_waited == TO);
`endif
        req = abort ? 1'b0 : (m_busy ? 1'b1 : access);
        stl = req && !s.ack;
        check("pc_src",        {63'd0, pc_src},   {63'd0, s.br & s.z});
        check("branch_target", branch_target, s.tgt);
        check("stall",         {63'd0, stall},    {63'd0, stl});
        check("dmem_req",      {63'd0, dmem_req}, {63'd0, req});
        check("dmem_we",       {63'd0, dmem_we},  {63'd0, s.wr});
        check("dmem_addr",     dmem_addr,  s.addr);
        check("dmem_wdata",    dmem_wdata, s.wdata);
        @(posedge clk);
        if (stl || abort) begin
            m_wb_rw  = 1'b0;
            m_wb_m2r = 1'b0;
        end else begin
            m_wb_rd  = s.dst;
            m_wb_alu = s.addr;
            m_wb_m2r = s.m2r;
            m_wb_rw  = s.rw;
            if (req && s.ack && s.rd && !s.wr) m_wb_rdata = s.rdata;
        end
        m_waited = (stl && m_busy) ? m_waited + 1 : 0;
        m_busy   = stl;
        m_err    = m_err | abort;
        #1;
        check_wb();
    endtask

    function automatic stim_t rand_instr();
        stim_t s;
        s.rd    = ($urandom_range(0, 9) < 3);
        s.wr    = ($urandom_range(0, 9) < 3);
        s.br    = ($urandom_range(0, 9) < 3);
        s.z     = $urandom_range(0, 1) == 1;
        s.ack   = 1'b0;
        s.m2r   = $urandom_range(0, 1) == 1;
        s.rw    = $urandom_range(0, 1) == 1;
        s.dst   = RA_W'($urandom);
        s.addr  = {$urandom, $urandom};
        s.wdata = {$urandom, $urandom};
        s.tgt   = {$urandom, $urandom};
        s.rdata = {$urandom, $urandom};
        return s;
    endfunction

    function automatic stim_t nop();
        stim_t s;
        s = rand_instr();
        s.rd = 1'b0;
        s.wr = 1'b0;
        s.br = 1'b0;
        return s;
    endfunction

    stim_t cur;

    initial begin
        // ---------------- reset state (inputs busy to prove forcing) -------
        reset         = 1'b0;
        mem_read_in   = 1'b1;
        mem_write_in  = 1'b0;
        branch_in     = 1'b1;
        zero_in       = 1'b1;
        dmem_ack      = 1'b0;
        mem_to_reg_in = 1'b1;
        reg_write_in  = 1'b1;
        rd_in         = 5'd7;
        alu_result_in = 64'h1234;
        read_data2_in = 64'h5678;
        adder_in      = 64'h100;
        dmem_rdata    = 64'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_dmem_req", {63'd0, dmem_req}, 64'd0);
        check("rst_stall",    {63'd0, stall},    64'd0);
        check("rst_pc_src",   {63'd0, pc_src},   64'd0);
        check_wb();
        @(negedge clk);
        reset = 1'b1;

        // ---------------- lw, zero-wait ack -------------------------------
        cur = nop();
        cur.rd = 1'b1; cur.rw = 1'b1; cur.m2r = 1'b1; cur.ack = 1'b1;
        cur.rdata = 64'hDEAD; cur.dst = 5'd3;
        step(cur);
        check("lw_rdata",  wb_read_data, 64'hDEAD);
        check("lw_rw",     {63'd0, wb_reg_write}, 64'd1);

        // ---------------- sw addr 0x40, ack after 3 cycles ----------------
        cur = nop();
        cur.wr = 1'b1; cur.rw = 1'b0; cur.addr = 64'h40;
        for (int i = 0; i < 3; i++) begin
            step(cur);
            check("sw_bubble", {63'd0, wb_reg_write}, 64'd0);
        end
        cur.ack = 1'b1;
        step(cur);
        check("sw_captured", wb_alu_result, 64'h40);

        // ---------------- branch taken / not taken ------------------------
        cur = nop();
        cur.br = 1'b1; cur.z = 1'b1; cur.tgt = 64'h100;
        step(cur);
        cur.z = 1'b0;
        step(cur);

        // ---------------- read+write together, stray ack ------------------
        cur = nop();
        cur.rd = 1'b1; cur.wr = 1'b1; cur.ack = 1'b1; cur.rw = 1'b1;
        step(cur);
        cur = nop();
        cur.ack = 1'b1; cur.rdata = 64'hBAD0;
        step(cur);

        // ---------------- reset in the middle of WAIT ---------------------
        cur = nop();
        cur.wr = 1'b1; cur.br = 1'b1; cur.z = 1'b1;
        step(cur);
        step(cur);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check("midrst_dmem_req", {63'd0, dmem_req}, 64'd0);
        check("midrst_stall",    {63'd0, stall},    64'd0);
        check("midrst_pc_src",   {63'd0, pc_src},   64'd0);
        check_wb();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        cur = nop();
        cur.rd = 1'b1; cur.ack = 1'b1; cur.rw = 1'b1; cur.rdata = 64'hBEEF;
        step(cur);
        check("post_rst_rdata", wb_read_data, 64'hBEEF);

`ifdef MEM_TIMEOUT_EN
        // ---------------- access timeout ----------------------------------
        cur = nop();
        cur.rd = 1'b1; cur.rw = 1'b1;
        for (int i = 0; i < TO + 1; i++) step(cur);
        cur.ack = 1'b1;           // late ack in the abort cycle is ignored
        step(cur);
        check("to_err", {63'd0, mem_err}, 64'd1);
        cur = nop();
        repeat (3) step(cur);
        check("to_err_sticky", {63'd0, mem_err}, 64'd1);
`endif

        // ---------------- randomized traffic ------------------------------
        for (int i = 0; i < 400; i++) begin
            if (!m_busy) cur = rand_instr();
            cur.ack   = ($urandom_range(0, 9) < 4);
            cur.rdata = {$urandom, $urandom};
            step(cur);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_mem_stage_ctrl
